// File: rtl/multi_pulse_generator_pkg.sv
// multi_pulse_pkg: shared state encoding and mode constants for the pulse generator
package multi_pulse_pkg;
    typedef enum logic {S_IDLE, S_RUN} channel_state_t;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;
endpackage

// File: rtl/multi_pulse_generator_if.sv
// multi_pulse_generator_if: per-channel control inputs and pulse outputs as packed arrays
interface multi_pulse_generator_if #(parameter int N = 8, parameter int CHANNELS = 4) ();
    logic [CHANNELS-1:0]        ena;
    logic [CHANNELS-1:0]        start;
    logic [CHANNELS-1:0]        mode;
    logic [CHANNELS-1:0][N-1:0] ticks;
    logic [CHANNELS-1:0][N-1:0] width;
    logic [CHANNELS-1:0]        out;
    logic [CHANNELS-1:0]        tick;
    logic [CHANNELS-1:0]        busy;
    logic [CHANNELS-1:0]        done;
    modport master (output ena, start, mode, ticks, width, input out, tick, busy, done);
    modport slave  (input ena, start, mode, ticks, width, output out, tick, busy, done);
endinterface

// File: rtl/multi_pulse_generator_channel.sv
// pulse_channel: one periodic/one-shot pulse channel; period, width and mode latched per period
module pulse_channel
    import multi_pulse_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] ticks,
    input  logic [N-1:0] width,
    output logic         out,
    output logic         tick,
    output logic         busy,
    output logic         done
);
    localparam logic [N-1:0] ONE = 1;
    channel_state_t state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d, p_q, p_d, w_q, w_d;
    logic         m_q, m_d, done_q, done_d;
    logic         last;

    assign last = cnt_q == p_q - ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            w_q     <= '0;
            m_q     <= MODE_PERIODIC;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            w_q     <= w_d;
            m_q     <= m_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        w_d     = w_q;
        m_d     = m_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (ena && ticks != '0 && (mode == MODE_PERIODIC || start)) begin
                state_d = S_RUN;
                cnt_d   = '0;
                p_d     = ticks;
                w_d     = width;
                m_d     = mode;
            end
        end else if (!ena) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (last) begin
            cnt_d = '0;
            if (m_q == MODE_ONESHOT) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                // Period boundary: pick up retuned settings, ticks==0 stops the train
                p_d     = ticks;
                w_d     = width;
                m_d     = mode;
                state_d = ticks == '0 ? S_IDLE : S_RUN;
            end
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_comb begin
        busy = state_q == S_RUN;
        out  = busy && cnt_q < w_q;
        tick = busy && last;
        done = done_q;
    end
endmodule

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: CHANNELS independent pulse_channel instances behind one interface
module multi_pulse_generator
    import multi_pulse_pkg::*;
#(
    parameter int N        = 8,
    parameter int CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_pulse_generator_if.slave  bus
);
    logic [CHANNELS-1:0] out_w, tick_w, busy_w, done_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_channel #(.N(N)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .ena   (bus.ena[i]),
            .start (bus.start[i]),
            .mode  (bus.mode[i]),
            .ticks (bus.ticks[i]),
            .width (bus.width[i]),
            .out   (out_w[i]),
            .tick  (tick_w[i]),
            .busy  (busy_w[i]),
            .done  (done_w[i])
        );
    end

    assign bus.out  = out_w;
    assign bus.tick = tick_w;
    assign bus.busy = busy_w;
    assign bus.done = done_w;
endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: directed vectors with hand-computed expectations for multi_pulse_generator
module tb_multi_pulse_generator;
    logic clk, rst;
    int   checks, errors, nt;
    logic [15:0] exp_o, exp_t;

    multi_pulse_generator_if #(.N(8), .CHANNELS(4)) ifc ();
    multi_pulse_generator #(.N(8), .CHANNELS(4)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic idle_all();
        ifc.ena   = '0;
        ifc.start = '0;
        ifc.mode  = '0;
        ifc.ticks = '0;
        ifc.width = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        ifc.ena   = '1;
        ifc.start = '0;
        ifc.mode  = '0;
        ifc.ticks = {4{8'd5}};
        ifc.width = {4{8'd2}};
        repeat (2) begin
            @(negedge clk);
            check("rst_out", ifc.out, 0);
            check("rst_tick", ifc.tick, 0);
            check("rst_busy", ifc.busy, 0);
            check("rst_done", ifc.done, 0);
        end
        rst = 1'b1;
        #1 check("rel_busy", ifc.busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rel_busy_run", ifc.busy, 4'hF);
            check("rel_out", ifc.out, i < 2 ? 4'hF : 4'h0);
            check("rel_tick", ifc.tick, i == 4 ? 4'hF : 4'h0);
        end

        do_reset();
        ifc.ena[0] = 1'b1; ifc.ticks[0] = 8'd4; ifc.width[0] = 8'd1;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("per_out", ifc.out, (i % 4 == 0) ? 1 : 0);
            check("per_tick", ifc.tick, (i % 4 == 3) ? 1 : 0);
            check("per_busy", ifc.busy, 1);
            if (ifc.tick[0]) nt++;
        end
        check("per_ntick", nt, 10);

        do_reset();
        ifc.ena[0] = 1'b1; ifc.ticks[0] = 8'd4; ifc.width[0] = 8'd2;
        exp_o = 16'h1C73;
        exp_t = 16'h8208;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("retune_out", ifc.out[0], exp_o[i]);
            check("retune_tick", ifc.tick[0], exp_t[i]);
            if (i == 1) begin
                ifc.ticks[0] = 8'd6;
                ifc.width[0] = 8'd3;
            end
        end

        do_reset();
        ifc.ena[0] = 1'b1; ifc.mode[0] = 1'b1; ifc.ticks[0] = 8'd3; ifc.width[0] = 8'd1;
        @(negedge clk);
        check("os_wait_busy", ifc.busy, 0);
        ifc.start[0] = 1'b1;
        @(negedge clk);
        ifc.start[0] = 1'b0;
        check("os_k1", {ifc.busy[0], ifc.out[0], ifc.tick[0], ifc.done[0]}, 4'b1100);
        @(negedge clk);
        check("os_k2", {ifc.busy[0], ifc.out[0], ifc.tick[0], ifc.done[0]}, 4'b1000);
        ifc.start[0] = 1'b1;
        @(negedge clk);
        ifc.start[0] = 1'b0;
        check("os_k3", {ifc.busy[0], ifc.out[0], ifc.tick[0], ifc.done[0]}, 4'b1010);
        @(negedge clk);
        check("os_k4", {ifc.busy[0], ifc.out[0], ifc.tick[0], ifc.done[0]}, 4'b0001);
        @(negedge clk);
        check("os_k5", {ifc.busy[0], ifc.done[0]}, 2'b00);
        ifc.ticks[0] = 8'd0;
        ifc.start[0] = 1'b1;
        @(negedge clk);
        ifc.start[0] = 1'b0;
        check("os_t0_busy", ifc.busy, 0);
        @(negedge clk);
        check("os_t0_done", ifc.done, 0);

        do_reset();
        ifc.ena[0] = 1'b1; ifc.ticks[0] = 8'd8; ifc.width[0] = 8'd6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ab_out", ifc.out[0], 1);
        end
        ifc.ena[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ab_off", {ifc.busy[0], ifc.out[0], ifc.tick[0], ifc.done[0]}, 4'b0000);
        end
        ifc.ena[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("ab_re_out", ifc.out[0], i < 6 ? 1 : 0);
            check("ab_re_tick", ifc.tick[0], i == 7 ? 1 : 0);
        end

        do_reset();
        ifc.ena[0] = 1'b1; ifc.ticks[0] = 8'd1; ifc.width[0] = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("p1", {ifc.busy[0], ifc.out[0], ifc.tick[0]}, 3'b111);
        end

        do_reset();
        ifc.ena[0] = 1'b1; ifc.ticks[0] = 8'd5; ifc.width[0] = 8'd255;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("wfull_out", ifc.out[0], 1);
            check("wfull_tick", ifc.tick[0], (i % 5 == 4) ? 1 : 0);
        end

        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("arst", {ifc.busy, ifc.out, ifc.tick, ifc.done}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_pulse_generator.md
# multi_pulse_generator

Parametrised multi-channel pulse generator: CHANNELS independent channels, each producing a programmable-period, programmable-width pulse train (periodic mode) or a single pulse window (one-shot mode). Period and width are latched per period, so software/upstream logic may retune a running channel without glitches. It drives timing strobes for display scanning, debouncers and sampling in the etch-a-sketch datapath.

## Interface
- N, 8, counter/period/width bit width
- CHANNELS, 4, number of independent channels
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-low reset
- ena  input  [CHANNELS-1:0]  per-channel enable; low aborts and holds channel idle
- start  input  [CHANNELS-1:0]  one-shot launch strobe, one cycle
- mode  input  [CHANNELS-1:0]  0 = periodic, 1 = one-shot
- ticks  input  [CHANNELS-1:0][N-1:0]  period in clocks; 0 = channel disabled
- width  input  [CHANNELS-1:0][N-1:0]  high-time in clocks within each period
- out  output  [CHANNELS-1:0]  pulse output
- tick  output  [CHANNELS-1:0]  one-cycle strobe in last cycle of each period
- busy  output  [CHANNELS-1:0]  channel in RUN
- done  output  [CHANNELS-1:0]  one-cycle strobe after a one-shot completes

## Operation
- Per channel, two states: IDLE, RUN. Counter cnt (N bits), latched p_lat, w_lat, m_lat.
- IDLE -> RUN: periodic when ena & mode==0 & ticks!=0; one-shot when ena & mode==1 & start & ticks!=0. On entry cnt=0, p_lat=ticks, w_lat=width, m_lat=mode.
- RUN: cnt increments each cycle. At cnt==p_lat-1: periodic -> cnt=0, relatch p_lat/w_lat from inputs (if new ticks==0 -> IDLE); one-shot -> IDLE, done pulses next cycle.
- RUN & !ena -> IDLE immediately, cnt=0, no done, no tick.
- out = RUN & (cnt < w_lat); width 0 -> never high; width >= p_lat -> high for whole period.
- tick = RUN & (cnt == p_lat-1). busy = RUN.
- start while RUN ignored; mode/ticks/width changes while RUN take effect only at the period boundary (periodic) or next launch (one-shot).
- start with ticks==0 or ena low ignored, no done.
- p_lat==1: tick and (width>=1) out high every RUN cycle.
- Comparisons unsigned, N bits; cnt never exceeds p_lat-1, so no wrap past 2^N-1.

## Timing
- Reset (rst low, async): all channels IDLE, cnt=0, latches 0; out, tick, busy, done all 0.
- Launch sampled at edge E; first RUN cycle (cnt=0) is the cycle after E; out/tick/busy are combinational from state registers only (no input-to-output path).
- done is a registered one-cycle pulse in the cycle following the final tick; busy low in that same cycle.
- ena deassert sampled at edge E: busy/out/tick low from the cycle after E.
- Channels fully independent; simultaneous events on different channels do not interact.

## Structure
- Package multi_pulse_pkg: typedef enum {S_IDLE, S_RUN} channel_state_t; localparams MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
- Sub-module pulse_channel (one channel, parameter N) holding the FSM, counter and latches; top instantiates it CHANNELS times in a generate loop and wires the packed arrays.

## Test plan
- Reset: hold rst low with ena all 1, ticks=5 -> all outputs 0; release -> periodic channels enter RUN next cycle.
- Periodic ticks=4, width=1: out high 1 of every 4 cycles, tick on cnt=3, period exactly 4 cycles over 10 periods.
- Retune: periodic ticks=4 width=2, change to ticks=6 width=3 mid-period -> current period stays 4/2, next period 6/3, no short/extra pulse.
- One-shot ticks=3 width=1, start at cycle k -> busy k+1..k+3, out k+1, tick k+3, done k+4; second start at k+2 ignored.
- Abort: periodic ticks=8, drop ena at cnt=5 -> outputs low next cycle, no tick/done; re-raise -> restarts at cnt=0.
- Corners: ticks=0 with start -> nothing; ticks=1 width=1 -> out and tick high every cycle; width=255 ticks=5 -> out constant high; async rst mid-RUN -> immediate zero outputs.
